// File: rtl/sprite_attr_ram_pkg.sv
// sprite_attr_ram_pkg: shared widths and readback state encodings for the sprite attribute RAM
package sprite_attr_ram_pkg;
  localparam int SPRAM_AW = 8;
  localparam int SPRAM_DW = 16;
  localparam int SPRAM_BW = 2;
  typedef enum logic [1:0] {RB_IDLE, RB_DRAIN, RB_ISSUE, RB_DONE} rb_state_t;
  function automatic int went_w(input int aw);
    return aw + SPRAM_DW + SPRAM_BW;
  endfunction
endpackage

// File: rtl/sprite_attr_ram_wfifo.sv
// spram_wfifo: synchronous posted-write FIFO, no bypass; push on full is dropped even with a pop
module spram_wfifo #(
  parameter int DEPTH = 4,
  parameter int W = 26
) (
  input  logic                     VCLKx4,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge VCLKx4)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge VCLKx4)
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/sprite_attr_ram.sv
// sprite_attr_ram: 256x16 sprite attribute RAM with posted CPU writes and priority engine reads
// Optional CPU readback FSM enabled by defining SPRAM_READBACK_EN.
module sprite_attr_ram
  import sprite_attr_ram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AW = SPRAM_AW
) (
  input  logic          VCLKx4,
  input  logic          RESET,
  input  logic          SPARE,
  input  logic [AW-1:0] SPAAD,
  output logic [15:0]   SPADT,
  input  logic          CPU_WR,
  input  logic [AW-1:0] CPU_AD,
  input  logic [15:0]   CPU_DI,
  input  logic [1:0]    CPU_BE,
  output logic          CPU_RDY,
  input  logic          CPU_RD,
  input  logic [AW-1:0] CPU_RA,
  output logic [15:0]   CPU_DO,
  output logic          CPU_DV
);
  localparam int EW = went_w(AW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] ram_lo [2**AW];
  logic [7:0] ram_hi [2**AW];
  logic [EW-1:0] head;
  logic [AW-1:0] head_ad;
  logic [15:0] head_di;
  logic [1:0] head_be;
  logic [CW-1:0] count;
  logic full, empty, pop, rb_hold;
  assign {head_ad, head_di, head_be} = head;
  assign CPU_RDY = ~full;
  // the single RAM port goes to the engine first, then the readback, then retirement
  assign pop = ~RESET & ~SPARE & ~empty & ~rb_hold;
  spram_wfifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_wfifo (
    .VCLKx4(VCLKx4),
    .RESET(RESET),
    .push(CPU_WR),
    .pop(pop),
    .din({CPU_AD, CPU_DI, CPU_BE}),
    .dout(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge VCLKx4) begin
    if (pop && head_be[0]) ram_lo[head_ad] <= head_di[7:0];
    if (pop && head_be[1]) ram_hi[head_ad] <= head_di[15:8];
  end
  always_ff @(posedge VCLKx4)
    if (RESET) SPADT <= '0;
    else if (SPARE) SPADT <= {ram_hi[SPAAD], ram_lo[SPAAD]};
`ifdef SPRAM_READBACK_EN
  rb_state_t rb_state;
  logic [AW-1:0] rb_ad;
  logic [CW-1:0] rb_ahead;
  // writes pushed after CPU_RD stay parked until the readback has sampled the RAM
  assign rb_hold = rb_state == RB_ISSUE || (rb_state == RB_DRAIN && rb_ahead == '0);
  always_ff @(posedge VCLKx4)
    if (RESET) begin
      rb_state <= RB_IDLE;
      rb_ad <= '0;
      rb_ahead <= '0;
      CPU_DO <= '0;
      CPU_DV <= 1'b0;
    end else begin
      CPU_DV <= 1'b0;
      case (rb_state)
        RB_IDLE: if (CPU_RD) begin
          rb_ad <= CPU_RA;
          rb_ahead <= count - CW'(pop);
          rb_state <= RB_DRAIN;
        end
        RB_DRAIN: if (rb_ahead == '0) rb_state <= RB_ISSUE;
                  else rb_ahead <= rb_ahead - CW'(pop);
        RB_ISSUE: if (!SPARE) begin
          CPU_DO <= {ram_hi[rb_ad], ram_lo[rb_ad]};
          CPU_DV <= 1'b1;
          rb_state <= RB_DONE;
        end
        default: rb_state <= RB_IDLE;
      endcase
    end
`else
  logic unused_rb;
  assign rb_hold = 1'b0;
  assign CPU_DO = '0;
  assign CPU_DV = 1'b0;
  assign unused_rb = ^{CPU_RD, CPU_RA, count};
`endif
endmodule

// File: tb/tb_sprite_attr_ram.sv
// tb_sprite_attr_ram: table-driven and sequence checks of sprite_attr_ram engine reads, FIFO and readback
module tb_sprite_attr_ram;
  logic VCLKx4 = 1'b0;
  logic RESET = 1'b1;
  logic SPARE = 1'b0;
  logic [7:0] SPAAD = '0;
  logic [15:0] SPADT;
  logic CPU_WR = 1'b0;
  logic [7:0] CPU_AD = '0;
  logic [15:0] CPU_DI = '0;
  logic [1:0] CPU_BE = '0;
  logic CPU_RDY;
  logic CPU_RD = 1'b0;
  logic [7:0] CPU_RA = '0;
  logic [15:0] CPU_DO;
  logic CPU_DV;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q [$];

  typedef struct {
    logic sp;
    logic [7:0] sa;
    logic wr;
    logic [7:0] ad;
    logic [15:0] di;
    logic [1:0] be;
    logic [15:0] exp;
  } vec_t;
  vec_t tv [$];

  sprite_attr_ram #(.FIFO_DEPTH(4), .AW(8)) dut (
    .VCLKx4(VCLKx4), .RESET(RESET), .SPARE(SPARE), .SPAAD(SPAAD), .SPADT(SPADT),
    .CPU_WR(CPU_WR), .CPU_AD(CPU_AD), .CPU_DI(CPU_DI), .CPU_BE(CPU_BE), .CPU_RDY(CPU_RDY),
    .CPU_RD(CPU_RD), .CPU_RA(CPU_RA), .CPU_DO(CPU_DO), .CPU_DV(CPU_DV)
  );

  always #5 VCLKx4 = ~VCLKx4;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sp, input logic [7:0] sa, input logic wr, input logic [7:0] ad,
                       input logic [15:0] di, input logic [1:0] be, input logic [15:0] exp);
    SPARE = sp; SPAAD = sa; CPU_WR = wr; CPU_AD = ad; CPU_DI = di; CPU_BE = be;
    if (sp) exp_q.push_back(exp);
    @(posedge VCLKx4);
    #1;
    if (sp) check($sformatf("spadt@%h", sa), SPADT, exp_q.pop_front());
    SPARE = 1'b0; CPU_WR = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h0000);
  endtask

  function automatic vec_t wv(input logic [7:0] ad, input logic [15:0] di, input logic [1:0] be);
    return '{1'b0, 8'h00, 1'b1, ad, di, be, 16'h0000};
  endfunction
  function automatic vec_t rv(input logic [7:0] sa, input logic [15:0] exp);
    return '{1'b1, sa, 1'b0, 8'h00, 16'h0000, 2'b00, exp};
  endfunction
  function automatic vec_t iv();
    return '{1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h0000};
  endfunction

  initial begin
    logic [7:0] pa [5];
    logic [15:0] pd [5];
    pa = '{8'h50, 8'h51, 8'h52, 8'h50, 8'h54};
    pd = '{16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'hDEAD};
    tv.push_back(wv(8'h10, 16'hA55A, 2'b11)); tv.push_back(iv()); tv.push_back(rv(8'h10, 16'hA55A));
    tv.push_back(wv(8'h20, 16'h1234, 2'b11)); tv.push_back(iv());
    tv.push_back(wv(8'h20, 16'hFFEE, 2'b01)); tv.push_back(iv()); tv.push_back(rv(8'h20, 16'h12EE));
    tv.push_back(wv(8'h20, 16'h5600, 2'b10)); tv.push_back(iv()); tv.push_back(rv(8'h20, 16'h56EE));
    tv.push_back(wv(8'h20, 16'h0000, 2'b00)); tv.push_back(iv()); tv.push_back(rv(8'h20, 16'h56EE));
    tv.push_back(wv(8'h05, 16'h1111, 2'b11)); tv.push_back(iv()); tv.push_back(rv(8'h05, 16'h1111));
    tv.push_back('{1'b1, 8'h05, 1'b1, 8'h05, 16'hBEEF, 2'b11, 16'h1111});
    tv.push_back(rv(8'h05, 16'h1111)); tv.push_back(rv(8'h05, 16'h1111));
    tv.push_back(iv()); tv.push_back(rv(8'h05, 16'hBEEF));
    tv.push_back(wv(8'h40, 16'hAAAA, 2'b11)); tv.push_back(wv(8'h40, 16'hBBBB, 2'b10));
    tv.push_back(iv()); tv.push_back(iv()); tv.push_back(rv(8'h40, 16'hBBAA));
    tv.push_back(wv(8'h54, 16'h7777, 2'b11)); tv.push_back(iv());
    tv.push_back(wv(8'h60, 16'h6060, 2'b11)); tv.push_back(wv(8'h61, 16'h6161, 2'b11));
    tv.push_back(wv(8'h62, 16'h6262, 2'b11));
    tv.push_back(iv()); tv.push_back(iv()); tv.push_back(iv());

    RESET = 1'b1;
    idle(); idle();
    RESET = 1'b0;
    check("reset_spadt", SPADT, 16'h0000);
    check("reset_rdy", {15'b0, CPU_RDY}, 16'h0001);
    check("reset_dv", {15'b0, CPU_DV}, 16'h0000);
    check("reset_do", CPU_DO, 16'h0000);

    foreach (tv[i]) drive(tv[i].sp, tv[i].sa, tv[i].wr, tv[i].ad, tv[i].di, tv[i].be, tv[i].exp);

    // FIFO fill while the engine monopolises the port
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h05, 1'b1, pa[i], pd[i], 2'b11, 16'hBEEF);
      check($sformatf("full_rdy%0d", i), {15'b0, CPU_RDY}, {15'b0, i < 3});
    end
    idle();
    check("rdy_after_pop", {15'b0, CPU_RDY}, 16'h0001);
    idle(); idle(); idle();
    drive(1'b1, 8'h50, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h1004);
    drive(1'b1, 8'h51, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h1002);
    drive(1'b1, 8'h52, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h1003);
    drive(1'b1, 8'h54, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h7777);

    // reset with pending writes discards them
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h60, 1'b1, 8'h60 + 8'(i), 16'hFFFF, 2'b11, 16'h6060);
    RESET = 1'b1;
    idle();
    RESET = 1'b0;
    check("rst2_rdy", {15'b0, CPU_RDY}, 16'h0001);
    check("rst2_spadt", SPADT, 16'h0000);
    idle(); idle();
    drive(1'b1, 8'h60, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h6060);
    drive(1'b1, 8'h61, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h6161);
    drive(1'b1, 8'h62, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h6262);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h60, 1'b1, 8'h70 + 8'(i), 16'h7000, 2'b11, 16'h6060);
      check($sformatf("rst2_fill%0d", i), {15'b0, CPU_RDY}, {15'b0, i < 3});
    end
    idle(); idle(); idle(); idle();

`ifdef SPRAM_READBACK_EN
    begin
      int pulses = 0;
      logic [15:0] got = '0;
      drive(1'b1, 8'h05, 1'b1, 8'h30, 16'h0F0F, 2'b11, 16'hBEEF);
      CPU_RD = 1'b1; CPU_RA = 8'h30;
      drive(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000, 2'b00, 16'hBEEF);
      CPU_RD = 1'b0;
      drive(1'b1, 8'h05, 1'b1, 8'h30, 16'h1234, 2'b11, 16'hBEEF);
      check("rb_dv_held", {15'b0, CPU_DV}, 16'h0000);
      drive(1'b1, 8'h05, 1'b0, 8'h00, 16'h0000, 2'b00, 16'hBEEF);
      check("rb_dv_held2", {15'b0, CPU_DV}, 16'h0000);
      for (int k = 0; k < 20; k++) begin
        idle();
        if (CPU_DV) begin
          pulses++;
          got = CPU_DO;
        end
      end
      check("rb_pulses", 16'(pulses), 16'h0001);
      check("rb_do", got, 16'h0F0F);
      drive(1'b1, 8'h30, 1'b0, 8'h00, 16'h0000, 2'b00, 16'h1234);
    end
`else
    CPU_RD = 1'b1; CPU_RA = 8'h05;
    idle();
    CPU_RD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      check("norb_dv", {15'b0, CPU_DV}, 16'h0000);
      check("norb_do", CPU_DO, 16'h0000);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sprite_attr_ram.md
Name: sprite_attr_ram

Overview:
- CPU-side owner and read responder for the 256x16 sprite attribute RAM that the sprite engine scans each line.
- Accepts posted 16-bit CPU word writes with byte enables into a small write FIFO.
- Retires those writes into RAM on cycles where the engine is not reading.
- Answers engine reads with fixed 1-cycle latency; engine reads always have priority.

Parameters:
- FIFO_DEPTH, 4, posted-write FIFO entries (power of two, 2..16).
- AW, 8, attribute RAM word-address width (256 words).

Ports:
- VCLKx4  in  1  single clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- SPARE  in  1  engine read request this cycle.
- SPAAD  in  AW  engine read word address.
- SPADT  out  16  engine read data.
- CPU_WR  in  1  CPU write request; accepted when CPU_WR & CPU_RDY.
- CPU_AD  in  AW  CPU write word address.
- CPU_DI  in  16  CPU write data.
- CPU_BE  in  2  byte enables; [1]=bits 15:8, [0]=bits 7:0.
- CPU_RDY  out  1  FIFO can accept a write.
- CPU_RD  in  1  CPU readback request, single-cycle pulse (SPRAM_READBACK_EN only).
- CPU_RA  in  AW  CPU readback address (SPRAM_READBACK_EN only).
- CPU_DO  out  16  readback data (SPRAM_READBACK_EN only).
- CPU_DV  out  1  readback data valid, 1-cycle pulse (SPRAM_READBACK_EN only).

Behaviour:
- Storage: two 256x8 byte lanes, one RAM port shared between engine reads and write retirement. RAM contents are not cleared by reset.
- Engine read: when SPARE=1 in cycle N, SPADT = {hi[SPAAD], lo[SPAAD]} registered at the end of cycle N and valid during N+1. SPADT holds its value when SPARE=0.
- SPADT reset value: 0x0000.
- Write FIFO push: CPU_WR & CPU_RDY pushes {CPU_AD, CPU_DI, CPU_BE}.
- CPU_RDY = (count != FIFO_DEPTH), driven combinationally from the registered count.
- A push on a full FIFO is ignored, even if a pop happens in the same cycle.
- CPU_BE=2'b00 is pushed and retired as a no-op.
- Write retirement: the FIFO head pops and writes enabled lanes at the head address in any cycle with SPARE=0 and count!=0. At most one retirement per cycle.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Ordering: writes retire in push order. Same-address writes are never merged.
- Hazard rule: no forwarding. An engine read returns RAM contents as of that cycle, so writes still in the FIFO are invisible.
- A retirement in cycle N is visible to an engine read issued in N+1.
- Pointers: rd/wr pointers of log2(FIFO_DEPTH) bits wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- Reset (including mid-operation): FIFO emptied (pending writes discarded), count=0, CPU_RDY=1 in the first cycle after RESET deasserts, SPADT=0, CPU_DO=0, CPU_DV=0, readback FSM returns to IDLE.
- Starvation: if SPARE is held high continuously, writes never retire and CPU_RDY falls once the FIFO is full. This is permitted; the engine leaves idle cycles on every line.

Optional Feature:
- Macro: SPRAM_READBACK_EN.
- With the macro: a CPU readback FSM.
  - IDLE: CPU_RD latches CPU_RA and moves to DRAIN.
  - DRAIN: wait until the FIFO is empty, then move to ISSUE.
  - ISSUE: read RAM in the first cycle with SPARE=0 and FIFO empty, then move to DONE.
  - DONE: CPU_DO <= data, CPU_DV=1 for one cycle, then IDLE.
  - The engine keeps priority throughout.
  - CPU_WR is still accepted during DRAIN/ISSUE. Those new writes are ordered after the readback and are not reflected in CPU_DO.
  - CPU_RD outside IDLE is ignored.
- Without the macro: CPU_RD and CPU_RA are ignored, CPU_DO=0, CPU_DV=0, and no FSM logic exists.

Decomposition:
- Shared package holds:
  - SPRAM_AW = 8.
  - Write-entry field widths (address, data, BE).
  - Readback state encodings (IDLE, DRAIN, ISSUE, DONE).
- One natural sub-module, spram_wfifo: a parameterised synchronous FIFO with push/pop/count/full/empty, no bypass path.

Test Plan:
1. Reset then a CPU write: CPU_WR with AD=0x10, DI=0xA55A, BE=11, SPARE=0. Then SPARE=1 at AD 0x10 two cycles later -> SPADT=0xA55A the cycle after the read.
2. Byte lane: RAM[0x20]=0x1234, then write DI=0xFFEE with BE=01 -> engine read returns 0x12EE. A following write with BE=10 and DI=0x5600 -> read returns 0x56EE.
3. Hold SPARE=1 and push 5 writes with FIFO_DEPTH=4 -> CPU_RDY=0 after the 4th push and the 5th is dropped. Release SPARE -> 4 writes retire in order over 4 cycles and CPU_RDY returns to 1 after the first pop.
4. Hazard: push write 0xBEEF to 0x05 while SPARE=1 reads 0x05 continuously -> SPADT keeps its old value. Drop SPARE for 1 cycle, then re-read -> 0xBEEF.
5. RESET asserted with 3 pending writes -> count=0 and CPU_RDY=1 after deassert. Read of those addresses returns the pre-existing values.
6. (SPRAM_READBACK_EN) Write 0x0F0F to 0x30, then immediately CPU_RD with RA=0x30 -> CPU_DV pulses once with CPU_DO=0x0F0F, only after the FIFO drains.
